pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Stage controls are a priority decode of the current hazard inputs (Mealy,
// zero latency). A small registered FSM tracks instruction/data memory waits,
// and a watchdog pulses o_Mem_Timeout while a data-memory miss persists.
// Optional build macro: HAZARD_PERF_CNT_EN enables the saturating stall/flush
// performance counters; without it both counter ports are tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | no outstanding memory wait
// DWAIT  | MEM stage waiting on data memory (watchdog counting)
// IWAIT  | fetch waiting on instruction memory

module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rs_Addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rt_Addr,
  input  logic                      i_ID_Uses_Rs,
  input  logic                      i_ID_Uses_Rt,
  input  logic                      i_EX_Mem_Valid,
  input  logic                      i_EX_Mem_Read_Write_n,
  input  logic                      i_EX_Writes_Back,
  input  logic [REG_ADDR_WIDTH-1:0] i_EX_Write_Addr,
  input  logic                      i_EX_Branch_Taken,
  input  logic                      i_IF_Mem_Ready,
  input  logic                      i_MEM_Mem_Valid,
  input  logic                      i_MEM_Mem_Ready,
  output logic                      o_PC_Write_En,
  output logic                      o_IF_ID_Stall,
  output logic                      o_IF_ID_Flush,
  output logic                      o_ID_EX_Stall,
  output logic                      o_ID_EX_Flush,
  output logic                      o_EX_MEM_Stall,
  output logic                      o_EX_MEM_Flush,
  output logic                      o_MEM_WB_Stall,
  output logic                      o_MEM_WB_Flush,
  output logic [1:0]                o_State,
  output logic                      o_Mem_Timeout,
  output logic [CNT_WIDTH-1:0]      o_Stall_Count,
  output logic [CNT_WIDTH-1:0]      o_Flush_Count
);

  localparam int WD_WIDTH = $clog2(MEM_TIMEOUT);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic dmem_miss;
  logic imem_miss;
  logic load_use;
  logic rs_match;
  logic rt_match;

  logic [WD_WIDTH-1:0] wd_cnt;
  logic                wd_hit;

  // Hazard terms
  assign dmem_miss = i_MEM_Mem_Valid & ~i_MEM_Mem_Ready;
  assign imem_miss = ~i_IF_Mem_Ready;
  assign rs_match  = i_ID_Uses_Rs & (i_ID_Rs_Addr == i_EX_Write_Addr);
  assign rt_match  = i_ID_Uses_Rt & (i_ID_Rt_Addr == i_EX_Write_Addr);
  assign load_use  = i_EX_Mem_Valid & i_EX_Mem_Read_Write_n & i_EX_Writes_Back &
                     (i_EX_Write_Addr != '0) & (rs_match | rt_match);

  // Priority decode of stage controls; each row drives stall or flush of a
  // stage, never both, so the per-stage exclusivity holds by construction.
  always_comb begin
    o_PC_Write_En  = 1'b0;
    o_IF_ID_Stall  = 1'b0;
    o_IF_ID_Flush  = 1'b0;
    o_ID_EX_Stall  = 1'b0;
    o_ID_EX_Flush  = 1'b0;
    o_EX_MEM_Stall = 1'b0;
    o_EX_MEM_Flush = 1'b0;
    o_MEM_WB_Stall = 1'b0;
    o_MEM_WB_Flush = 1'b0;
    if (i_Reset) begin
      o_IF_ID_Flush  = 1'b1;
      o_ID_EX_Flush  = 1'b1;
      o_EX_MEM_Flush = 1'b1;
      o_MEM_WB_Flush = 1'b1;
    end else if (dmem_miss) begin
      o_IF_ID_Stall  = 1'b1;
      o_ID_EX_Stall  = 1'b1;
      o_EX_MEM_Stall = 1'b1;
      o_MEM_WB_Flush = 1'b1;
    end else if (i_EX_Branch_Taken) begin
      // The redirect kills the younger instructions, so any load-use or
      // fetch wait against them is moot.
      o_IF_ID_Flush  = 1'b1;
      o_ID_EX_Flush  = 1'b1;
      o_PC_Write_En  = 1'b1;
    end else if (load_use) begin
      o_IF_ID_Stall  = 1'b1;
      o_ID_EX_Flush  = 1'b1;
    end else if (imem_miss) begin
      o_IF_ID_Flush  = 1'b1;
    end else begin
      o_PC_Write_En  = 1'b1;
    end
  end

  // Wait-tracking state register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait-tracking next-state logic
  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN: begin
        if (dmem_miss) begin
          state_nxt = ST_DWAIT;
        end else if (imem_miss && !i_EX_Branch_Taken) begin
          state_nxt = ST_IWAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DWAIT: begin
        if (dmem_miss) begin
          state_nxt = ST_DWAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_IWAIT: begin
        if (dmem_miss) begin
          state_nxt = ST_DWAIT;
        end else if (i_IF_Mem_Ready) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IWAIT;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign o_State = state;

  // The watchdog counts every consecutive miss cycle, including the one that
  // moves the FSM into DWAIT, so a pulse follows exactly MEM_TIMEOUT miss
  // cycles. A miss always means DWAIT is (or is about to be) the state, and
  // DWAIT is left only when the miss clears, which also clears the count.
  assign wd_hit = dmem_miss & (wd_cnt == WD_LAST);

  // Watchdog counter and registered timeout pulse
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wd_cnt        <= '0;
      o_Mem_Timeout <= 1'b0;
    end else begin
      o_Mem_Timeout <= wd_hit;
      if (!dmem_miss || wd_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_WIDTH'(1);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic                 branch_fire;

  // Branch row fires only when no data-memory miss outranks it.
  assign branch_fire = i_EX_Branch_Taken & ~dmem_miss;

  // Saturating performance counters
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!o_PC_Write_En && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (branch_fire && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_Stall_Count = stall_cnt;
  assign o_Flush_Count = flush_cnt;
`else
  assign o_Stall_Count = '0;
  assign o_Flush_Count = '0;
`endif

endmodule
